// File: rtl/l2pa_sched_if.sv
// L2PA-side bundle of the layer scheduler: shift-ROM load/address, permutation mode and beat handshake.
interface l2pa_sched_if #(
    parameter int SHIFT_LENGTH = 255,
    parameter int LAYER_W      = 4
);
    logic [SHIFT_LENGTH-1:0] shiftROM_load_en_o;
    logic [LAYER_W-1:0]      rom_layer_o;
    logic                    isMsgPass_o;
    logic                    l2pa_valid_o;
    logic                    l2pa_ready_i;

    modport master (
        output shiftROM_load_en_o,
        output rom_layer_o,
        output isMsgPass_o,
        output l2pa_valid_o,
        input  l2pa_ready_i
    );

    modport slave (
        input  shiftROM_load_en_o,
        input  rom_layer_o,
        input  isMsgPass_o,
        input  l2pa_valid_o,
        output l2pa_ready_i
    );
endinterface

// File: rtl/l2pa_sched_ctrl.sv
// Layer scheduler for one L2PA instance: per layer a shift-ROM load, then a handshaked permutation phase.
// Build option L2PA_SCHED_LOAD_ALL_EN: load all ROM columns in a single cycle instead of a one-hot walk.
//
// state  | meaning
// S_IDLE | waiting for start_i with a nonzero layer count
// S_LOAD | loading shift-ROM columns for the current layer
// S_PERM | V2C/C2V permutation, PERM_BEATS accepted beats
// S_DONE | one-cycle completion pulse, then back to idle
module l2pa_sched_ctrl #(
    parameter int SHIFT_LENGTH = 255,
    parameter int PERM_BEATS   = 4,
    parameter int LAYER_W      = 4
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [LAYER_W-1:0] layer_num_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    l2pa_sched_if.master       l2pa
);
    localparam int COL_W  = (SHIFT_LENGTH > 1) ? $clog2(SHIFT_LENGTH) : 1;
    localparam int BEAT_W = (PERM_BEATS > 1) ? $clog2(PERM_BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PERM, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt;
    logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
    logic [LAYER_W-1:0] r_layer, w_layer_nxt;
    logic [LAYER_W-1:0] r_layer_num, w_layer_num_nxt;
    logic               w_col_last, w_beat_last, w_layer_last;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_beat      <= '0;
            r_layer     <= '0;
            r_layer_num <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_beat      <= w_beat_nxt;
            r_layer     <= w_layer_nxt;
            r_layer_num <= w_layer_num_nxt;
        end
    end

`ifdef L2PA_SCHED_LOAD_ALL_EN
    assign w_col_last = 1'b1;
`else
    assign w_col_last = (r_col == COL_W'(SHIFT_LENGTH - 1));
`endif
    assign w_beat_last  = (r_beat == BEAT_W'(PERM_BEATS - 1));
    // r_layer_num is never zero outside idle, so the subtraction cannot wrap here.
    assign w_layer_last = (r_layer == r_layer_num - LAYER_W'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_beat_nxt      = r_beat;
        w_layer_nxt     = r_layer;
        w_layer_num_nxt = r_layer_num;
        case (r_state)
            S_IDLE: begin
                if (start_i && (layer_num_i != '0)) begin
                    w_layer_num_nxt = layer_num_i;
                    w_layer_nxt     = '0;
                    w_col_nxt       = '0;
                    w_beat_nxt      = '0;
                    w_state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_col_last) begin
                    w_col_nxt   = '0;
                    w_state_nxt = S_PERM;
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end
            S_PERM: begin
                if (l2pa.l2pa_ready_i) begin
                    if (w_beat_last) begin
                        w_beat_nxt = '0;
                        if (w_layer_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_layer_nxt = r_layer + LAYER_W'(1);
                            w_state_nxt = S_LOAD;
                        end
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_layer_nxt     = '0;
                w_layer_num_nxt = '0;
                w_state_nxt     = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i) begin
            w_state_nxt     = S_IDLE;
            w_col_nxt       = '0;
            w_beat_nxt      = '0;
            w_layer_nxt     = '0;
            w_layer_num_nxt = '0;
        end
    end

`ifdef L2PA_SCHED_LOAD_ALL_EN
    assign l2pa.shiftROM_load_en_o = (r_state == S_LOAD) ? '1 : '0;
`else
    assign l2pa.shiftROM_load_en_o = (r_state == S_LOAD) ? (SHIFT_LENGTH'(1) << r_col) : '0;
`endif
    assign l2pa.rom_layer_o  = r_layer;
    assign l2pa.isMsgPass_o  = (r_state == S_PERM);
    assign l2pa.l2pa_valid_o = (r_state == S_PERM);
    assign busy_o            = (r_state != S_IDLE);
    assign done_o            = (r_state == S_DONE);
endmodule

// File: tb/tb_l2pa_sched_ctrl.sv
// Scoreboard bench for l2pa_sched_ctrl with SHIFT_LENGTH=3, PERM_BEATS=4: per-cycle expected outputs are queued by the stimulus and popped by a monitor.
module tb_l2pa_sched_ctrl;
    typedef struct packed {
        logic [2:0] ld;
        logic [3:0] layer;
        logic       msg;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [3:0] layer_num;
    logic       abort;
    logic       busy, done;
    int         n_checks = 0;
    int         n_errors = 0;
    int         tnum = 0;
    exp_t       q[$];

    always #5 clk = ~clk;

    l2pa_sched_if #(.SHIFT_LENGTH(3), .LAYER_W(4)) u_if ();

    l2pa_sched_ctrl #(.SHIFT_LENGTH(3), .PERM_BEATS(4), .LAYER_W(4)) u_dut (
        .sys_clk     (clk),
        .rstn        (rstn),
        .start_i     (start),
        .layer_num_i (layer_num),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .l2pa        (u_if.master)
    );

    function automatic exp_t actual();
        return {u_if.shiftROM_load_en_o, u_if.rom_layer_o, u_if.isMsgPass_o, u_if.l2pa_valid_o, busy, done};
    endfunction

    function automatic exp_t e_idle();
        return '0;
    endfunction
    function automatic exp_t e_ld(input logic [2:0] ld, input logic [3:0] l);
        return {ld, l, 1'b0, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic exp_t e_pm(input logic [3:0] l);
        return {3'b000, l, 1'b1, 1'b1, 1'b1, 1'b0};
    endfunction
    function automatic exp_t e_dn(input logic [3:0] l);
        return {3'b000, l, 1'b0, 1'b0, 1'b1, 1'b1};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s test%0d t=%0t got ld=%b layer=%0d msg=%b vld=%b busy=%b done=%b want ld=%b layer=%0d msg=%b vld=%b busy=%b done=%b",
                     name, tnum, $time, got.ld, got.layer, got.msg, got.valid, got.busy, got.done,
                     want.ld, want.layer, want.msg, want.valid, want.busy, want.done);
        end
    endtask

    // One stimulus cycle: inputs for this cycle plus the outputs expected during it.
    task automatic cyc(input logic st, input logic [3:0] ln, input logic ab, input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        start = st;
        layer_num = ln;
        abort = ab;
        u_if.l2pa_ready_i = rdy;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("cycle_out", actual(), e);
        end
    end

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        layer_num = '0;
        abort = 1'b0;
        u_if.l2pa_ready_i = 1'b1;
        #1;
        check("reset_state", actual(), e_idle());
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cyc(0, 0, 0, 1, e_idle());

`ifdef L2PA_SCHED_LOAD_ALL_EN
        tnum = 6;
        cyc(1, 2, 0, 1, e_idle());
        for (int l = 0; l < 2; l++) begin
            cyc(0, 0, 0, 1, e_ld(3'b111, 4'(l)));
            for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, e_pm(4'(l)));
        end
        cyc(0, 0, 0, 1, e_dn(4'd1));
        cyc(0, 0, 0, 1, e_idle());
`else
        tnum = 1;
        cyc(1, 2, 0, 1, e_idle());
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, e_ld(3'(1 << k), 4'(l)));
            for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, e_pm(4'(l)));
        end
        cyc(0, 0, 0, 1, e_dn(4'd1));
        cyc(0, 0, 0, 1, e_idle());

        tnum = 2;
        cyc(1, 1, 0, 1, e_idle());
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, e_ld(3'(1 << k), 4'd0));
        cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(0, 0, 0, 0, e_pm(4'd0));
        cyc(0, 0, 0, 0, e_pm(4'd0));
        for (int b = 0; b < 3; b++) cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(0, 0, 0, 1, e_dn(4'd0));
        cyc(0, 0, 0, 1, e_idle());

        tnum = 3;
        cyc(1, 2, 0, 1, e_idle());
        cyc(0, 0, 0, 1, e_ld(3'b001, 4'd0));
        cyc(0, 0, 1, 1, e_ld(3'b010, 4'd0));
        cyc(1, 1, 0, 1, e_idle());
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, e_ld(3'(1 << k), 4'd0));
        for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(0, 0, 0, 1, e_dn(4'd0));
        cyc(1, 1, 1, 1, e_idle());
        cyc(0, 0, 0, 1, e_idle());

        tnum = 4;
        cyc(1, 0, 0, 1, e_idle());
        cyc(0, 0, 0, 1, e_idle());
        cyc(1, 1, 0, 1, e_idle());
        cyc(1, 3, 0, 1, e_ld(3'b001, 4'd0));
        cyc(0, 0, 0, 1, e_ld(3'b010, 4'd0));
        cyc(0, 0, 0, 1, e_ld(3'b100, 4'd0));
        for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(1, 2, 0, 1, e_dn(4'd0));
        cyc(0, 0, 0, 1, e_idle());
        cyc(0, 0, 0, 1, e_idle());

        tnum = 5;
        cyc(1, 2, 0, 1, e_idle());
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, e_ld(3'(1 << k), 4'd0));
        cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(0, 0, 0, 1, e_pm(4'd0));
        #6 rstn = 1'b0;
        #1 check("async_reset", actual(), e_idle());
        cyc(0, 0, 0, 1, e_idle());
        cyc(0, 0, 0, 1, e_idle());
        rstn = 1'b1;
        cyc(0, 0, 0, 1, e_idle());
        cyc(1, 1, 0, 1, e_idle());
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, e_ld(3'(1 << k), 4'd0));
        for (int b = 0; b < 4; b++) cyc(0, 0, 0, 1, e_pm(4'd0));
        cyc(0, 0, 0, 1, e_dn(4'd0));
        cyc(0, 0, 0, 1, e_idle());
`endif

        begin
            int guard;
            guard = 0;
            while (q.size() != 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (q.size() != 0) begin
                n_errors++;
                $display("FAIL scoreboard_drain got %0d entries left want 0", q.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
